// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and FSM encoding for the instruction-fetch front end
//  FETCH_XLEN/FETCH_RESET_PC/FETCH_PC_STEP/FETCH_QDEPTH: parameter defaults for fetch_unit
//  fetch_state_e: IDLE (no fetching), FETCH (issuing), DRAIN (discarding stale responses)
package fetch_pkg;
  localparam int FETCH_XLEN = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;
  localparam int FETCH_PC_STEP = 4;
  localparam int FETCH_QDEPTH = 4;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with flush and occupancy count
//  i_clk        clock
//  i_rst        synchronous active-low reset
//  i_flush      empty the FIFO (wins over push/pop)
//  i_push/i_din write an entry (ignored when full)
//  i_pop        drop the head entry (ignored when empty)
//  o_valid      FIFO non-empty; o_dout is the head entry
//  o_count      number of stored entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [W-1:0]           i_din,
  input  logic                   i_pop,
  output logic                   o_valid,
  output logic [W-1:0]           o_dout,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign w_push = i_push && (r_cnt != (AW+1)'(DEPTH));
  assign w_pop = i_pop && (r_cnt != '0);
  assign o_valid = r_cnt != '0;
  assign o_dout = r_mem[r_rp];
  assign o_count = r_cnt;
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end (PC, imem request tracking, redirect, decode queue)
//  i_clk/i_rst           clock, synchronous active-low reset
//  i_en                  fetch enable
//  o_imem_req/o_imem_addr  request strobe and address (always accepted)
//  i_imem_rvalid/i_imem_rdata  in-order responses
//  i_redirect_valid/i_redirect_pc  branch redirect pulse and target
//  o_out_valid/i_out_ready/o_out_pc/o_out_instr  decode-side queue head
//  o_pc                  next fetch PC
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC),
  parameter int PC_STEP = FETCH_PC_STEP,
  parameter int QDEPTH = FETCH_QDEPTH
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_pc,
  output logic [XLEN-1:0] o_out_instr,
  output logic [XLEN-1:0] o_pc
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] OCC_MAX = (CW+1)'(QDEPTH);
  fetch_state_e r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt, w_tag;
  logic [CW-1:0] r_drop, w_drop_nxt, w_q_cnt, w_outstanding, w_out_after;
  logic [CW:0] w_occ;
  logic [2*XLEN-1:0] w_head;
  logic w_tag_valid, w_rv, w_req, w_push, w_pop;
  // The tag FIFO holds one entry per request in flight, so its occupancy is the
  // outstanding count; responses with nothing in flight (stale after reset) are ignored.
  assign w_rv = i_imem_rvalid && w_tag_valid;
  assign w_out_after = w_outstanding - CW'(w_rv);
  // Queue slots plus in-flight requests bound issue, so a response always finds room.
  assign w_occ = {1'b0, w_q_cnt} + {1'b0, w_outstanding};
  assign w_req = (r_state == FETCH) && i_en && !i_redirect_valid && (w_occ < OCC_MAX);
  assign w_push = w_rv && !i_redirect_valid && (r_drop == '0);
  assign w_pop = o_out_valid && i_out_ready;
  // Everything still in flight after a redirect cycle belongs to the old path.
  assign w_drop_nxt = i_redirect_valid ? w_out_after : r_drop - CW'(w_rv && (r_drop != '0));
  assign w_pc_nxt = i_redirect_valid ? {i_redirect_pc[XLEN-1:2], 2'b00} :
                    w_req ? r_pc + XLEN'(PC_STEP) : r_pc;
  assign o_imem_req = w_req;
  assign o_imem_addr = r_pc;
  assign o_pc = r_pc;
  assign o_out_pc = w_head[2*XLEN-1:XLEN];
  assign o_out_instr = w_head[XLEN-1:0];
  always_comb begin
    w_state_nxt = r_state;
    if (i_redirect_valid) w_state_nxt = (w_out_after != '0) ? DRAIN : FETCH;
    else if (r_state == DRAIN) w_state_nxt = (w_drop_nxt != '0) ? DRAIN : (i_en ? FETCH : IDLE);
    else w_state_nxt = i_en ? FETCH : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
      r_drop <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc <= w_pc_nxt;
      r_drop <= w_drop_nxt;
    end
  end
  fetch_queue #(.W(XLEN), .DEPTH(QDEPTH)) u_tag (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (1'b0),
    .i_push  (w_req),
    .i_din   (r_pc),
    .i_pop   (w_rv),
    .o_valid (w_tag_valid),
    .o_dout  (w_tag),
    .o_count (w_outstanding)
  );
  fetch_queue #(.W(2*XLEN), .DEPTH(QDEPTH)) u_iq (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_redirect_valid),
    .i_push  (w_push),
    .i_din   ({w_tag, i_imem_rdata}),
    .i_pop   (w_pop),
    .o_valid (o_out_valid),
    .o_dout  (w_head),
    .o_count (w_q_cnt)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard and vector bench for fetch_unit
module tb_fetch_unit;
  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} exp_t;
  typedef struct {logic [31:0] addr; int due;} pend_t;
  typedef struct {logic [31:0] rpc; logic [31:0] exp_pc; logic [31:0] exp_next;} vec_t;
  logic clk = 0, rst = 0, en = 0, rvalid = 0, redir = 0, ready = 0;
  logic [31:0] rdata = 0, rpc = 0;
  logic req, ov;
  logic [31:0] addr, opc, oinstr, pc;
  int total = 0, bad = 0, lat = 1, cyc_n = 0;
  exp_t sb[$];
  pend_t pend[$];
  logic [31:0] req_log[$];
  vec_t vecs[4];
  always #5 clk = ~clk;
  fetch_unit dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_en             (en),
    .o_imem_req       (req),
    .o_imem_addr      (addr),
    .i_imem_rvalid    (rvalid),
    .i_imem_rdata     (rdata),
    .i_redirect_valid (redir),
    .i_redirect_pc    (rpc),
    .o_out_valid      (ov),
    .i_out_ready      (ready),
    .o_out_pc         (opc),
    .o_out_instr      (oinstr),
    .o_pc             (pc)
  );
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (req === 1'b1) pend.push_back('{addr, cyc_n + lat});
    if (!rst) sb.delete();
    else if (redir) begin
      chk("redirect_noreq", 32'(req), 0);
      sb.delete();
    end else begin
      if (ov === 1'b1 && ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got pc %h want none", opc);
        end else begin
          e = sb.pop_front();
          chk("out_pc", opc, e.pc);
          chk("out_instr", oinstr, e.instr);
        end
      end
      if (req === 1'b1) begin
        sb.push_back('{addr, mem_word(addr)});
        req_log.push_back(addr);
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (pend.size() > 0 && pend[0].due <= cyc_n) begin
      rvalid = 1;
      rdata = mem_word(pend[0].addr);
      pend.delete(0);
    end else begin
      rvalid = 0;
      rdata = 32'hDEAD_BEEF;
    end
  endtask
  task automatic run_reqs(int n);
    int n0, k;
    n0 = req_log.size();
    k = 0;
    en = 1;
    while (req_log.size() < n0 + n && k < 40) begin
      cyc();
      k++;
    end
    en = 0;
    chk("req_issue", req_log.size(), n0 + n);
  endtask
  task automatic drain();
    int k;
    k = 0;
    en = 0;
    ready = 1;
    while ((sb.size() > 0 || ov === 1'b1) && k < 40) begin
      cyc();
      k++;
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_ov", 32'(ov), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n0;
    vecs[0] = '{32'h0000_4002, 32'h0000_4000, 32'h0000_4004};
    vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0004};
    vecs[3] = '{32'h1234_5677, 32'h1234_5674, 32'h1234_5678};
    rst = 0;
    en = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_pc", pc, 32'h3000);
      chk("rst_req", 32'(req), 0);
      chk("rst_ov", 32'(ov), 0);
    end
    rst = 1;
    ready = 1;
    lat = 1;
    run_reqs(3);
    chk("seq_a0", req_log[0], 32'h3000);
    chk("seq_a1", req_log[1], 32'h3004);
    chk("seq_a2", req_log[2], 32'h3008);
    drain();
    ready = 0;
    en = 1;
    n0 = req_log.size();
    for (int i = 0; i < 10; i++) cyc();
    chk("bp_fill_reqs", req_log.size() - n0, 4);
    chk("bp_req_low", 32'(req), 0);
    chk("bp_full_ov", 32'(ov), 1);
    ready = 1;
    n0 = req_log.size();
    cyc();
    ready = 0;
    for (int i = 0; i < 6; i++) cyc();
    chk("bp_one_more", req_log.size() - n0, 1);
    chk("bp_req_low2", 32'(req), 0);
    drain();
    lat = 3;
    ready = 1;
    run_reqs(2);
    en = 1;
    redir = 1;
    rpc = 32'h0000_4002;
    cyc();
    redir = 0;
    chk("redir_pc", pc, 32'h4000);
    n0 = req_log.size();
    cyc();
    cyc();
    chk("redir_drain_noreq", req_log.size() - n0, 0);
    run_reqs(1);
    chk("redir_addr", req_log[$], 32'h4000);
    drain();
    lat = 1;
    ready = 0;
    run_reqs(3);
    chk("flush_prefill_ov", 32'(ov), 1);
    en = 1;
    redir = 1;
    rpc = 32'h0000_5000;
    cyc();
    redir = 0;
    chk("flush_ov", 32'(ov), 0);
    chk("flush_pc", pc, 32'h5000);
    ready = 1;
    run_reqs(2);
    chk("flush_addr", req_log[req_log.size()-2], 32'h5000);
    drain();
    foreach (vecs[i]) begin
      lat = 2;
      ready = 1;
      en = 1;
      redir = 1;
      rpc = vecs[i].rpc;
      cyc();
      redir = 0;
      chk("vec_pc", pc, vecs[i].exp_pc);
      run_reqs(1);
      chk("vec_addr", req_log[$], vecs[i].exp_pc);
      chk("vec_next", pc, vecs[i].exp_next);
      drain();
    end
    lat = 3;
    ready = 1;
    run_reqs(3);
    n0 = req_log.size();
    for (int i = 0; i < 8; i++) cyc();
    chk("en_off_noreq", req_log.size() - n0, 0);
    chk("en_off_delivered", sb.size(), 0);
    lat = 2;
    ready = 0;
    run_reqs(3);
    chk("mrst_prefill_ov", 32'(ov), 1);
    rst = 0;
    cyc();
    rst = 1;
    chk("mrst_pc", pc, 32'h3000);
    chk("mrst_ov", 32'(ov), 0);
    ready = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("mrst_stale_ov", 32'(ov), 0);
    end
    run_reqs(1);
    chk("mrst_addr", req_log[$], 32'h3000);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
